// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC fetch stage: reset/exception addresses,
// redirect-buffer state encoding and request-priority encoding.
package pc_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_0180;

    // RUN: no redirect buffered; PEND: a redirect is waiting for the stall to release.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_e;

    // Live request, ordered so that a larger value means a higher priority.
    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_JUMP = 2'd1,
        REQ_BR   = 2'd2,
        REQ_EXC  = 2'd3
    } req_e;

    // Collapse the three redirect strobes into a single prioritised request.
    function automatic req_e encode_req(input logic exc, input logic br, input logic jump);
        if (exc)       return REQ_EXC;
        else if (br)   return REQ_BR;
        else if (jump) return REQ_JUMP;
        else           return REQ_NONE;
    endfunction

    // Target address belonging to a prioritised request.
    function automatic logic [31:0] req_target(input req_e r,
                                               input logic [31:0] br_target,
                                               input logic [31:0] jump_target);
        case (r)
            REQ_EXC: return EXC_VECTOR;
            REQ_BR:  return br_target;
            default: return jump_target;
        endcase
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: redirect/stall requests in, imem address and controls out.
interface pc_fetch_unit_if;
    logic        hold;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        exc;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        imem_hold;
    logic        imem_clr;
    logic [31:0] pc_id;
    logic        valid_id;
    logic        misalign_err;

    // Pipeline control side: drives stalls and redirects, observes the fetch stage.
    modport master (
        output hold, br_taken, br_target, jump, jump_target, exc,
        input  pc, pc_plus4, imem_hold, imem_clr, pc_id, valid_id, misalign_err
    );

    // Fetch unit side.
    modport slave (
        input  hold, br_taken, br_target, jump, jump_target, exc,
        output pc, pc_plus4, imem_hold, imem_clr, pc_id, valid_id, misalign_err
    );
endinterface

// File: rtl/pc_fetch_unit_redirect_buf.sv
// Pending-redirect buffer: captures redirects that arrive during a stall and
// merges the buffered request with the live one when the stall releases.
module pc_redirect_buf
    import pc_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  req_e        live_req,
    input  logic [31:0] live_target,
    output logic        apply_valid,
    output logic [31:0] apply_target,
    output logic        pend_valid
);

    state_e      state_q, state_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        pend_exc_q, pend_exc_d;
    logic        pend_valid_q, pend_valid_d;

    logic live_valid;
    logic live_exc;

    assign live_valid = (live_req != REQ_NONE);
    assign live_exc   = (live_req == REQ_EXC);
    assign pend_valid = pend_valid_q;

    // Merge live and buffered redirects; only issued on an unstalled cycle.
    always_comb begin
        apply_valid  = 1'b0;
        apply_target = live_target;
        if (!hold) begin
            if (state_q == ST_PEND) begin
                apply_valid = 1'b1;
                // Live exception > buffered exception > live branch/jump > buffer.
                if (live_exc)
                    apply_target = live_target;
                else if (pend_exc_q)
                    apply_target = pend_target_q;
                else if (live_valid)
                    apply_target = live_target;
                else
                    apply_target = pend_target_q;
            end else if (live_valid) begin
                apply_valid = 1'b1;
            end
        end
    end

    // Buffer state: newest redirect wins, except a buffered exception is sticky.
    always_comb begin
        state_d       = state_q;
        pend_target_d = pend_target_q;
        pend_exc_d    = pend_exc_q;
        pend_valid_d  = pend_valid_q;
        case (state_q)
            ST_RUN: begin
                if (hold && live_valid) begin
                    pend_target_d = live_target;
                    pend_exc_d    = live_exc;
                    pend_valid_d  = 1'b1;
                    state_d       = ST_PEND;
                end
            end
            ST_PEND: begin
                if (hold) begin
                    if (live_valid && (live_exc || !pend_exc_q)) begin
                        pend_target_d = live_target;
                        pend_exc_d    = live_exc;
                    end
                end else begin
                    pend_valid_d = 1'b0;
                    pend_exc_d   = 1'b0;
                    state_d      = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Register buffer state; reset drops any pending redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            pend_target_q <= 32'h0;
            pend_exc_q    <= 1'b0;
            pend_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_target_q <= pend_target_d;
            pend_exc_q    <= pend_exc_d;
            pend_valid_q  <= pend_valid_d;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC generation stage ahead of the instruction memory: holds the PC, picks the
// next fetch address, drives imem hold/clr and tracks the PC of the
// instruction currently presented by imem.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    pc_fetch_unit_if.slave bus
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic        valid_id_q, valid_id_d;
    logic        misalign_q, misalign_d;

    req_e        live_req;
    logic [31:0] live_target;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        pend_valid;

    assign live_req    = encode_req(bus.exc, bus.br_taken, bus.jump);
    assign live_target = req_target(live_req, bus.br_target, bus.jump_target);

    pc_redirect_buf u_redirect_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .hold         (bus.hold),
        .live_req     (live_req),
        .live_target  (live_target),
        .apply_valid  (redirect),
        .apply_target (redirect_target),
        .pend_valid   (pend_valid)
    );

    // Redirects only fire when unstalled, so clr and hold are never both high.
    assign bus.imem_clr     = redirect;
    assign bus.imem_hold    = bus.hold && !redirect;
    assign bus.pc           = pc_q;
    assign bus.pc_plus4     = pc_q + 32'd4;
    assign bus.pc_id        = pc_id_q;
    assign bus.valid_id     = valid_id_q;
    assign bus.misalign_err = misalign_q;

    // Next-PC selection and the PC/valid pair that tracks imem's registered output.
    always_comb begin
        pc_d       = pc_q;
        pc_id_d    = pc_id_q;
        valid_id_d = valid_id_q;
        misalign_d = misalign_q;
        if (!bus.hold) begin
            if (redirect) begin
                pc_d       = {redirect_target[31:2], 2'b00};
                pc_id_d    = 32'h0;
                valid_id_d = 1'b0;
                misalign_d = misalign_q | (redirect_target[1:0] != 2'b00);
            end else begin
                pc_d       = pc_q + 32'd4;
                pc_id_d    = pc_q;
                valid_id_d = 1'b1;
            end
        end
    end

    // PC and fetch-tracking state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            pc_id_q    <= 32'h0;
            valid_id_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_id_q    <= pc_id_d;
            valid_id_q <= valid_id_d;
            misalign_q <= misalign_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit.
module tb_pc_fetch_unit;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    pc_fetch_unit_if bus ();

    pc_fetch_unit u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.hold        = 1'b0;
        bus.br_taken    = 1'b0;
        bus.br_target   = 32'h0;
        bus.jump        = 1'b0;
        bus.jump_target = 32'h0;
        bus.exc         = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        tests++; if (bus.pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h0); end
        tests++; if (bus.pc_id !== 32'h0) begin fails++; $display("FAIL reset_pc_id: got %h want %h", bus.pc_id, 32'h0); end
        tests++; if (bus.valid_id !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.valid_id); end
        tests++; if (bus.misalign_err !== 1'b0) begin fails++; $display("FAIL reset_misalign: got %b want 0", bus.misalign_err); end
        tests++; if (bus.imem_clr !== 1'b0) begin fails++; $display("FAIL reset_clr: got %b want 0", bus.imem_clr); end
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            tests++; if (bus.pc !== 32'(4 * i)) begin fails++; $display("FAIL seq_pc[%0d]: got %h want %h", i, bus.pc, 32'(4 * i)); end
            tests++; if (bus.pc_id !== 32'(4 * (i - 1)) || bus.valid_id !== 1'b1) begin
                fails++; $display("FAIL seq_id[%0d]: got %h/%b want %h/1", i, bus.pc_id, bus.valid_id, 32'(4 * (i - 1)));
            end
        end
    endtask

    task automatic test_branch();
        do_reset();
        step();
        step();
        tests++; if (bus.pc !== 32'h8) begin fails++; $display("FAIL br_start_pc: got %h want %h", bus.pc, 32'h8); end
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h40;
        #1;
        tests++; if (bus.imem_clr !== 1'b1 || bus.imem_hold !== 1'b0) begin
            fails++; $display("FAIL br_clr: got clr=%b hold=%b want clr=1 hold=0", bus.imem_clr, bus.imem_hold);
        end
        step();
        bus.br_taken = 1'b0;
        tests++; if (bus.pc !== 32'h40 || bus.valid_id !== 1'b0) begin
            fails++; $display("FAIL br_pc: got %h/%b want 00000040/0", bus.pc, bus.valid_id);
        end
        step();
        tests++; if (bus.pc_id !== 32'h40 || bus.valid_id !== 1'b1 || bus.pc !== 32'h44) begin
            fails++; $display("FAIL br_id: got id=%h v=%b pc=%h want 00000040/1/00000044", bus.pc_id, bus.valid_id, bus.pc);
        end
        tests++; if (bus.pc_plus4 !== 32'h48) begin fails++; $display("FAIL br_plus4: got %h want %h", bus.pc_plus4, 32'h48); end
    endtask

    task automatic test_hold_pend();
        // pc = 0x44 on entry
        bus.hold        = 1'b1;
        bus.jump        = 1'b1;
        bus.jump_target = 32'h100;
        #1;
        tests++; if (bus.imem_hold !== 1'b1 || bus.imem_clr !== 1'b0) begin
            fails++; $display("FAIL hold_ctrl: got hold=%b clr=%b want 1/0", bus.imem_hold, bus.imem_clr);
        end
        step();
        bus.jump = 1'b0;
        bus.exc  = 1'b1;
        step();
        bus.exc = 1'b0;
        tests++; if (bus.pc !== 32'h44) begin fails++; $display("FAIL hold_frozen: got %h want %h", bus.pc, 32'h44); end
        step();
        tests++; if (bus.pc !== 32'h44 || bus.pc_id !== 32'h40 || bus.valid_id !== 1'b1) begin
            fails++; $display("FAIL hold_keep: got %h/%h/%b want 00000044/00000040/1", bus.pc, bus.pc_id, bus.valid_id);
        end
        bus.hold = 1'b0;
        #1;
        tests++; if (bus.imem_clr !== 1'b1 || bus.imem_hold !== 1'b0) begin
            fails++; $display("FAIL release_clr: got clr=%b hold=%b want 1/0", bus.imem_clr, bus.imem_hold);
        end
        step();
        tests++; if (bus.pc !== 32'h180 || bus.valid_id !== 1'b0) begin
            fails++; $display("FAIL release_pc: got %h/%b want 00000180/0", bus.pc, bus.valid_id);
        end
        tests++; if (bus.imem_clr !== 1'b0) begin fails++; $display("FAIL clr_one_cycle: got %b want 0", bus.imem_clr); end
        step();
        tests++; if (bus.pc !== 32'h184 || bus.pc_id !== 32'h180) begin
            fails++; $display("FAIL release_seq: got %h/%h want 00000184/00000180", bus.pc, bus.pc_id);
        end
        // buffered exception is not displaced by a later branch
        bus.hold = 1'b1; bus.exc = 1'b1;
        step();
        bus.exc = 1'b0; bus.br_taken = 1'b1; bus.br_target = 32'h40;
        step();
        bus.br_taken = 1'b0; bus.hold = 1'b0;
        step();
        tests++; if (bus.pc !== 32'h180) begin fails++; $display("FAIL sticky_exc: got %h want %h", bus.pc, 32'h180); end
        // newest buffered redirect wins
        bus.hold = 1'b1; bus.jump = 1'b1; bus.jump_target = 32'h100;
        step();
        bus.jump = 1'b0; bus.br_taken = 1'b1; bus.br_target = 32'h200;
        step();
        bus.br_taken = 1'b0; bus.hold = 1'b0;
        step();
        tests++; if (bus.pc !== 32'h200) begin fails++; $display("FAIL newest_wins: got %h want %h", bus.pc, 32'h200); end
        // live branch at release beats a buffered jump
        bus.hold = 1'b1; bus.jump = 1'b1; bus.jump_target = 32'h100;
        step();
        bus.jump = 1'b0; bus.hold = 1'b0; bus.br_taken = 1'b1; bus.br_target = 32'h300;
        step();
        bus.br_taken = 1'b0;
        tests++; if (bus.pc !== 32'h300) begin fails++; $display("FAIL live_beats_buf: got %h want %h", bus.pc, 32'h300); end
    endtask

    task automatic test_same_cycle();
        bus.exc = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h40;
        bus.jump = 1'b1; bus.jump_target = 32'h100;
        step();
        clear_inputs();
        tests++; if (bus.pc !== 32'h180) begin fails++; $display("FAIL priority_exc: got %h want %h", bus.pc, 32'h180); end
        bus.br_taken = 1'b1; bus.br_target = 32'h40; bus.jump = 1'b1; bus.jump_target = 32'h100;
        step();
        clear_inputs();
        tests++; if (bus.pc !== 32'h40) begin fails++; $display("FAIL priority_br: got %h want %h", bus.pc, 32'h40); end
    endtask

    task automatic test_misalign_wrap();
        tests++; if (bus.misalign_err !== 1'b0) begin fails++; $display("FAIL misalign_pre: got %b want 0", bus.misalign_err); end
        bus.br_taken = 1'b1; bus.br_target = 32'h43;
        step();
        bus.br_taken = 1'b0;
        tests++; if (bus.pc !== 32'h40 || bus.misalign_err !== 1'b1) begin
            fails++; $display("FAIL misalign_set: got %h/%b want 00000040/1", bus.pc, bus.misalign_err);
        end
        step();
        step();
        tests++; if (bus.misalign_err !== 1'b1) begin fails++; $display("FAIL misalign_sticky: got %b want 1", bus.misalign_err); end
        bus.jump = 1'b1; bus.jump_target = 32'hFFFF_FFFC;
        step();
        bus.jump = 1'b0;
        tests++; if (bus.pc !== 32'hFFFF_FFFC || bus.pc_plus4 !== 32'h0) begin
            fails++; $display("FAIL wrap_pre: got %h/%h want fffffffc/00000000", bus.pc, bus.pc_plus4);
        end
        step();
        tests++; if (bus.pc !== 32'h0 || bus.pc_id !== 32'hFFFF_FFFC || bus.valid_id !== 1'b1) begin
            fails++; $display("FAIL wrap: got %h/%h/%b want 00000000/fffffffc/1", bus.pc, bus.pc_id, bus.valid_id);
        end
    endtask

    task automatic test_reset_pend();
        bus.hold = 1'b1; bus.jump = 1'b1; bus.jump_target = 32'h200;
        step();
        bus.jump = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        tests++; if (bus.pc !== 32'h0 || bus.misalign_err !== 1'b0) begin
            fails++; $display("FAIL async_reset: got %h/%b want 00000000/0", bus.pc, bus.misalign_err);
        end
        clear_inputs();
        step();
        rst_n = 1'b1;
        #1;
        tests++; if (bus.imem_clr !== 1'b0) begin fails++; $display("FAIL pend_dropped_clr: got %b want 0", bus.imem_clr); end
        step();
        tests++; if (bus.pc !== 32'h4 || bus.pc_id !== 32'h0 || bus.valid_id !== 1'b1) begin
            fails++; $display("FAIL post_reset_fetch: got %h/%h/%b want 00000004/00000000/1", bus.pc, bus.pc_id, bus.valid_id);
        end
        step();
        tests++; if (bus.pc !== 32'h8) begin fails++; $display("FAIL post_reset_seq: got %h want %h", bus.pc, 32'h8); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_branch();
        test_hold_pend();
        test_same_cycle();
        test_misalign_wrap();
        test_reset_pend();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
